// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage pipelined carry-select subtractor computing d = a - b - bin.
// Stage 1 computes the low segment and both upper candidates; stage 2 selects the upper half with the registered low borrow.
module carry_select_subtractor_pipe #(
  parameter int unsigned IWL = 8,
  parameter int unsigned LSW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IWL-1:0] a,
  input  logic [IWL-1:0] b,
  input  logic           bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IWL-1:0] d,
  output logic           bout,
  output logic           ovf
);

  localparam int unsigned HW = IWL - LSW;

  logic           s1_valid;
  logic [LSW-1:0] s1_dlo;
  logic           s1_blo;
  logic [HW-1:0]  s1_dh0;
  logic           s1_bh0;
  logic [HW-1:0]  s1_dh1;
  logic           s1_bh1;
  logic           s1_amsb;
  logic           s1_bmsb;

  logic           adv1;
  logic           adv2;
  logic           accept;
  logic [LSW:0]   lo_sum;
  logic [HW:0]    hi0_sum;
  logic [HW:0]    hi1_sum;
  logic [HW-1:0]  hi_sel;
  logic [IWL-1:0] d_next;
  logic           bout_next;
  logic           ovf_next;

  // Handshake: stage 1 may load whenever it is empty or draining into stage 2.
  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;

  // Subtraction as a + ~b + ~bin; a segment's borrow is the inverse of its carry.
  always_comb begin
    lo_sum  = {1'b0, a[LSW-1:0]} + {1'b0, ~b[LSW-1:0]} + {{LSW{1'b0}}, ~bin};
    hi0_sum = {1'b0, a[IWL-1:LSW]} + {1'b0, ~b[IWL-1:LSW]} + (HW+1)'(1);
    hi1_sum = {1'b0, a[IWL-1:LSW]} + {1'b0, ~b[IWL-1:LSW]};
  end

  // Carry-select: the registered low borrow picks the upper candidate.
  always_comb begin
    hi_sel    = s1_blo ? s1_dh1 : s1_dh0;
    d_next    = {hi_sel, s1_dlo};
    bout_next = s1_blo ? s1_bh1 : s1_bh0;
    ovf_next  = (s1_amsb != s1_bmsb) && (hi_sel[HW-1] != s1_amsb);
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_blo   <= 1'b0;
      s1_dh0   <= '0;
      s1_bh0   <= 1'b0;
      s1_dh1   <= '0;
      s1_bh1   <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dlo  <= lo_sum[LSW-1:0];
        s1_blo  <= ~lo_sum[LSW];
        s1_dh0  <= hi0_sum[HW-1:0];
        s1_bh0  <= ~hi0_sum[HW];
        s1_dh1  <= hi1_sum[HW-1:0];
        s1_bh1  <= ~hi1_sum[HW];
        s1_amsb <= a[IWL-1];
        s1_bmsb <= b[IWL-1];
      end
    end
  end

  // Output register: loads on advance, clears after a transfer with nothing behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      d         <= d_next;
      bout      <= bout_next;
      ovf       <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
